paralleltoserial: RTL

PARALLELTOSERIAL -- requirements
Module: paralleltoserial

---
 rtl/paralleltoserial.sv | 124 ++++++++++++
 1 files changed

// File: rtl/paralleltoserial.sv
// Byte-wide to MSB-first serial converter: four COM bytes of preamble, then
// held data bytes or fill bytes. Define PTS_IDLE_FILL_EN to fill with IDL instead of COM.
module paralleltoserial #(
  parameter logic [7:0] COM = 8'hBC,
  parameter logic [7:0] IDL = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);

`ifdef PTS_IDLE_FILL_EN
  localparam logic FILL_SEL = 1'b1;
`else
  localparam logic FILL_SEL = 1'b0;
`endif
  localparam logic [7:0] FILL = FILL_SEL ? IDL : COM;

  typedef enum logic {
    PREAMBLE = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [2:0] bit_cnt_r;
  logic [1:0] com_cnt_r, com_cnt_nxt_s;
  logic       com_wrap_r, com_wrap_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic [7:0] hold_r, hold_nxt_s;
  logic       full_r, full_nxt_s;
  logic       data_out_nxt_s;
  logic       load_s, accept_s, unload_s, sel_active_s;

  // Next-state, byte selection and holding-register update
  always_comb begin
    state_nxt_s    = state_r;
    com_cnt_nxt_s  = com_cnt_r;
    com_wrap_nxt_s = com_wrap_r;
    shift_nxt_s    = shift_r;
    unload_s       = 1'b0;
    sel_active_s   = 1'b0;
    load_s         = (bit_cnt_r == 3'd0);
    accept_s       = valid_in & ready_out;

    // com_wrap_r marks that all four preamble bytes have been loaded
    case (state_r)
      PREAMBLE: begin
        if (load_s && com_wrap_r) begin
          sel_active_s = 1'b1;
          state_nxt_s  = ACTIVE;
        end else begin
          sel_active_s = 1'b0;
        end
      end
      ACTIVE: begin
        sel_active_s = 1'b1;
      end
      default: begin
        state_nxt_s = PREAMBLE;
      end
    endcase

    if (load_s) begin
      if (sel_active_s) begin
        if (full_r) begin
          shift_nxt_s = hold_r;
          unload_s    = 1'b1;
        end else begin
          shift_nxt_s = FILL;
        end
      end else begin
        shift_nxt_s    = COM;
        com_cnt_nxt_s  = com_cnt_r + 2'd1;
        com_wrap_nxt_s = com_wrap_r | (com_cnt_r == 2'd3);
      end
      data_out_nxt_s = shift_nxt_s[7];
    end else begin
      data_out_nxt_s = shift_r[3'd7 - bit_cnt_r];
    end

    if (accept_s) begin
      full_nxt_s = 1'b1;
      hold_nxt_s = data_in;
    end else if (unload_s) begin
      full_nxt_s = 1'b0;
      hold_nxt_s = hold_r;
    end else begin
      full_nxt_s = full_r;
      hold_nxt_s = hold_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_r    <= PREAMBLE;
      bit_cnt_r  <= 3'd0;
      com_cnt_r  <= 2'd0;
      com_wrap_r <= 1'b0;
      shift_r    <= 8'h00;
      hold_r     <= 8'h00;
      full_r     <= 1'b0;
      data_out   <= 1'b0;
      ready_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_r + 3'd1;
      com_cnt_r  <= com_cnt_nxt_s;
      com_wrap_r <= com_wrap_nxt_s;
      shift_r    <= shift_nxt_s;
      hold_r     <= hold_nxt_s;
      full_r     <= full_nxt_s;
      data_out   <= data_out_nxt_s;
      ready_out  <= ~full_nxt_s;
      active_out <= (state_nxt_s == ACTIVE);
    end
  end

endmodule
